// File: rtl/ethernet_system_desc_arb_pkg.sv
// Shared types and helpers for the descriptor RAM arbiter.
// Optional perf counters are enabled by DESC_ARB_PERF_CNT_EN.
package ethernet_system_desc_arb_pkg;

  typedef logic master_idx_t;

  localparam master_idx_t M0 = 1'b0;
  localparam master_idx_t M1 = 1'b1;

  localparam int HOLD_MAX_DEF = 4;

  typedef logic [$clog2(HOLD_MAX_DEF+1)-1:0] hold_cnt_t;

  function automatic master_idx_t other(input master_idx_t i);
    return ~i;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ethernet_system_desc_arb_rr.sv
// Round-robin grant with bounded hold for two masters.
// Owner keeps the port until the other waits HOLD_MAX grants.
module ethernet_system_desc_arb_rr
  import ethernet_system_desc_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam int HW = $clog2(HOLD_MAX+1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

  master_idx_t     owner_q, owner_d;
  master_idx_t     prio_q, prio_d;
  master_idx_t     win;
  logic            vld_q, vld_d;
  logic [HW-1:0]   hold_q, hold_d;

  always_comb begin
    win     = prio_q;
    gnt_o   = '0;
    owner_d = owner_q;
    prio_d  = prio_q;
    vld_d   = vld_q;
    hold_d  = hold_q;

    if (vld_q && req_i[owner_q]) begin
      if (req_i[other(owner_q)] && hold_q == HMAX)
        win = other(owner_q);
      else
        win = owner_q;
    end else if (req_i == 2'b11) begin
      win = prio_q;
    end else begin
      win = req_i[1] ? M1 : M0;
    end

    if (reset_n && (|req_i))
      gnt_o[win] = 1'b1;

    if (|gnt_o) begin
      prio_d = other(win);
      vld_d  = 1'b1;
      if (vld_q && owner_q == win) begin
        if (hold_q != HMAX)
          hold_d = hold_q + HW'(1);
      end else begin
        owner_d = win;
        hold_d  = HW'(1);
      end
    end else begin
      vld_d  = 1'b0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q <= M0;
      prio_q  <= M0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      prio_q  <= prio_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/ethernet_system_descriptor_arbiter.sv
// Two-master Avalon-MM arbiter in front of the descriptor RAM port.
// DESC_ARB_PERF_CNT_EN adds grant/conflict performance counters.
module ethernet_system_descriptor_arbiter
  import ethernet_system_desc_arb_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
`ifdef DESC_ARB_PERF_CNT_EN
  input  logic                perf_clr,
  output logic [31:0]         m0_grant_cnt,
  output logic [31:0]         m1_grant_cnt,
  output logic [31:0]         conflict_cnt,
`endif
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req, gnt, rd_only;
  logic [1:0] rd_pend_q, rd_pend_d;

  assign req     = {m1_read | m1_write, m0_read | m0_write};
  assign rd_only = {m1_read & ~m1_write, m0_read & ~m0_write};

  ethernet_system_desc_arb_rr #(
    .HOLD_MAX (HOLD_MAX)
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  assign m0_waitrequest = ~reset_n | (req[0] & ~gnt[0]);
  assign m1_waitrequest = ~reset_n | (req[1] & ~gnt[1]);

  assign mem_chipselect = |gnt;
  assign mem_clken      = 1'b1;

  // Idle cycles park the RAM port on m0's bus values.
  always_comb begin
    mem_address    = m0_address;
    mem_writedata  = m0_writedata;
    mem_byteenable = m0_byteenable;
    mem_write      = 1'b0;
    if (gnt[1]) begin
      mem_address    = m1_address;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      mem_byteenable = m1_write ? m1_byteenable : '1;
    end else if (gnt[0]) begin
      mem_write      = m0_write;
      mem_byteenable = m0_write ? m0_byteenable : '1;
    end
  end

  assign rd_pend_d = gnt & rd_only;

  always_ff @(posedge clk) begin
    if (!reset_n)
      rd_pend_q <= '0;
    else
      rd_pend_q <= rd_pend_d;
  end

  assign m0_readdatavalid = rd_pend_q[0];
  assign m1_readdatavalid = rd_pend_q[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef DESC_ARB_PERF_CNT_EN
  logic [31:0] g0_q, g1_q, cf_q;

  always_ff @(posedge clk) begin
    if (!reset_n || perf_clr) begin
      g0_q <= '0;
      g1_q <= '0;
      cf_q <= '0;
    end else begin
      if (gnt[0])
        g0_q <= sat_inc(g0_q);
      if (gnt[1])
        g1_q <= sat_inc(g1_q);
      if (&req)
        cf_q <= sat_inc(cf_q);
    end
  end

  assign m0_grant_cnt = g0_q;
  assign m1_grant_cnt = g1_q;
  assign conflict_cnt = cf_q;
`endif

endmodule

// File: tb/tb_ethernet_system_descriptor_arbiter.sv
// Bench for the descriptor RAM arbiter: directed steps plus random traffic
// against a queue-free behavioural arbitration and shadow-memory model.
module tb_ethernet_system_descriptor_arbiter;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;
`ifdef DESC_ARB_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif

  ethernet_system_descriptor_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_clken        (mem_clken),
`ifdef DESC_ARB_PERF_CNT_EN
    .perf_clr         (perf_clr),
    .m0_grant_cnt     (m0_grant_cnt),
    .m1_grant_cnt     (m1_grant_cnt),
    .conflict_cnt     (conflict_cnt),
`endif
    .mem_readdata     (mem_readdata)
  );

  // RAM: registered address, unregistered q
  logic [31:0] ram [0:2047];
  logic [31:0] shadow [0:2047];
  logic [10:0] ram_aq;

  always @(posedge clk) begin
    if (mem_clken) begin
      ram_aq <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b])
            ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
  end

  assign mem_readdata = ram[ram_aq];

  function automatic logic [31:0] initv(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  int total = 0;
  int bad   = 0;

  // reference model state
  int          lastg  = -1;
  int          streak = 0;
  int          prio   = 0;
  logic [1:0]  exp_rv = 2'b00;
  logic [31:0] exp_rd = '0;
  int          obs_g  = -1;
  logic        obs_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic r0, input logic r1);
    logic [1:0] r;
    r = {r1, r0};
    if (lastg >= 0 && r[lastg])
      return (r[1-lastg] && streak >= HOLD) ? 1 - lastg : lastg;
    if (r0 && r1) return prio;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic tick;
    logic        r0, r1, w;
    int          g;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    #2;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g  = reset_n ? model_grant(r0, r1) : -1;
    chk1("wait0", m0_waitrequest, !reset_n || (r0 && g != 0));
    chk1("wait1", m1_waitrequest, !reset_n || (r1 && g != 1));
    chk1("cs", mem_chipselect, g >= 0);
    chk1("rdv0", m0_readdatavalid, exp_rv[0]);
    chk1("rdv1", m1_readdatavalid, exp_rv[1]);
    if (exp_rv[0]) chk("rdata0", m0_readdata, exp_rd);
    if (exp_rv[1]) chk("rdata1", m1_readdata, exp_rd);
    obs_g  = !mem_chipselect ? -1 : (r0 && !m0_waitrequest) ? 0 : 1;
    obs_wr = mem_write;
    exp_rv = 2'b00;
    if (g >= 0) begin
      a  = g == 1 ? m1_address    : m0_address;
      w  = g == 1 ? m1_write      : m0_write;
      d  = g == 1 ? m1_writedata  : m0_writedata;
      be = g == 1 ? m1_byteenable : m0_byteenable;
      chk("addr", 32'(mem_address), 32'(a));
      chk1("mwr", mem_write, w);
      if (w) begin
        chk("wdata", mem_writedata, d);
        chk("be", 32'(mem_byteenable), 32'(be));
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        chk("be_rd", 32'(mem_byteenable), 32'hF);
        exp_rv[g] = 1'b1;
        exp_rd    = shadow[a];
      end
    end else begin
      chk("addr_idle", 32'(mem_address), 32'(m0_address));
    end
    if (!reset_n) begin
      lastg = -1; streak = 0; prio = 0;
    end else if (g >= 0) begin
      streak = (g == lastg) ? ((streak + 1 > HOLD) ? HOLD : streak + 1) : 1;
      lastg  = g;
      prio   = 1 - g;
    end else begin
      lastg = -1; streak = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  int k;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]    = initv(i);
      shadow[i] = initv(i);
    end
    ram[16]    = 32'hDEADBEEF;
    shadow[16] = 32'hDEADBEEF;
    reset_n = 0;
    idle();
    m0_address = 0; m1_address = 0;
    m0_writedata = 0; m1_writedata = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
`ifdef DESC_ARB_PERF_CNT_EN
    perf_clr = 0;
`endif
    @(negedge clk);
    tick();
    tick();
    reset_n = 1;

    // single m0 read
    m0_read = 1; m0_address = 11'h010;
    tick();
    chk("t1_gnt", 32'(obs_g), 32'd0);
    idle();
    chk1("t1_rdv0", m0_readdatavalid, 1'b1);
    chk("t1_data", m0_readdata, 32'hDEADBEEF);
    chk1("t1_rdv1", m1_readdatavalid, 1'b0);
    tick();

    // both streaming: bounded hold alternation
    reset_n = 0;
    tick();
    reset_n = 1;
    m0_read = 1; m1_read = 1;
    for (int i = 0; i < 16; i++) begin
      m0_address = 11'(i);
      m1_address = 11'(i + 32);
      tick();
      chk("t2_gnt", 32'(obs_g), 32'((i / 4) % 2));
    end
    idle();
    tick();

    // partial write at top address, then read back
    m1_write = 1; m1_address = 11'h7FF;
    m1_writedata = 32'hA5A5A5A5; m1_byteenable = 4'b0011;
    tick();
    chk("t3_wgnt", 32'(obs_g), 32'd1);
    idle();
    m0_read = 1; m0_address = 11'h7FF;
    tick();
    idle();
    chk1("t3_rdv", m0_readdatavalid, 1'b1);
    k = 2047;
    chk("t3_data", m0_readdata, {initv(k) >> 16, 16'hA5A5});
    tick();

    // read+write together is a write
    m0_read = 1; m0_write = 1; m0_address = 11'h005;
    m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
    tick();
    chk1("t4_memwr", obs_wr, 1'b1);
    idle();
    chk1("t4_no_rdv", m0_readdatavalid, 1'b0);
    tick();
    m0_read = 1;
    tick();
    idle();
    chk("t4_data", m0_readdata, 32'h12345678);
    tick();

    // reset in the middle of an m1 read burst
    reset_n = 0;
    tick();
    reset_n = 1;
    m1_read = 1; m1_address = 11'h001;
    tick();
    reset_n = 0; m1_address = 11'h002;
    #1;
    chk1("t5_rdv_kept", m1_readdatavalid, 1'b1);
    k = 1;
    chk("t5_data", m1_readdata, initv(k));
    chk1("t5_wait", m1_waitrequest, 1'b1);
    tick();
    m1_address = 11'h003;
    #1;
    chk1("t5_rdv_drop", m1_readdatavalid, 1'b0);
    chk1("t5_cs", mem_chipselect, 1'b0);
    tick();
    reset_n = 1;
    m0_read = 1; m0_address = 11'h004;
    tick();
    chk("t5_tie", 32'(obs_g), 32'd0);
    idle();
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      k = $urandom_range(0, 3);
      m0_read  = (k == 1 || k == 3);
      m0_write = (k >= 2);
      k = $urandom_range(0, 3);
      m1_read  = (k == 1 || k == 3);
      m1_write = (k >= 2);
      k = $urandom_range(0, 8);
      m0_address = (k == 8) ? 11'h7FF : 11'(k);
      k = $urandom_range(0, 8);
      m1_address = (k == 8) ? 11'h7FF : 11'(k);
      m0_writedata  = $urandom;
      m1_writedata  = $urandom;
      m0_byteenable = 4'($urandom_range(0, 15));
      m1_byteenable = 4'($urandom_range(0, 15));
      tick();
    end
    reset_n = 1;
    idle();
    tick();

`ifdef DESC_ARB_PERF_CNT_EN
    reset_n = 0;
    tick();
    reset_n = 1;
    m0_read = 1; m1_read = 1;
    repeat (10) tick();
    idle();
    #1;
    chk("t6_conf", conflict_cnt, 32'd10);
    chk("t6_sum", m0_grant_cnt + m1_grant_cnt, 32'd10);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("t6_clr_conf", conflict_cnt, 32'd0);
    chk("t6_clr_g0", m0_grant_cnt, 32'd0);
    chk("t6_clr_g1", m1_grant_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
